// File: rtl/unsigned_div_seq_2nbyn_if.sv
// Operand/result handshake bundle for the sequential 2N-by-N unsigned divider.
// The master side supplies operands and accepts results; the slave side is the divider.
interface unsigned_div_seq_2nbyn_if #(
   parameter int N = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [2*N-1:0] z;
   logic [N-1:0]   y;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   x;
   logic [N-1:0]   r;
   logic           ovf;

   modport master (
      output in_valid, z, y, out_ready,
      input  in_ready, out_valid, x, r, ovf
   );

   modport slave (
      input  in_valid, z, y, out_ready,
      output in_ready, out_valid, x, r, ovf
   );
endinterface

// File: rtl/unsigned_div_seq_2nbyn.sv
// Radix-2 restoring divider: 2N-bit z / N-bit y -> N-bit quotient x, remainder r, one bit per clock.
// Optional round-to-nearest quotient via macro DIV_ROUND_EN.
module unsigned_div_seq_2nbyn #(
   parameter int N = 8
) (
   input logic                    clk,
   input logic                    rst,
   unsigned_div_seq_2nbyn_if.slave bus
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_reg, state_next;
   logic [N-1:0]    z_low_reg, z_low_next;
   logic [N-1:0]    y_reg, y_next;
   logic [N-1:0]    rem_reg, rem_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [N-1:0]    q_reg, q_next;
   logic [N-1:0]    x_reg, x_next;
   logic [N-1:0]    r_reg, r_next;
   logic            ovf_reg, ovf_next;

   // Trial value is N+1 bits wide; the stored remainder is always below y so N bits hold it.
   logic [N:0]      t;
   logic            t_ge;
   logic [N-1:0]    rem_step;
   logic [N-1:0]    quo;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         z_low_reg <= '0;
         y_reg     <= '0;
         rem_reg   <= '0;
         cnt_reg   <= '0;
         q_reg     <= '0;
         x_reg     <= '0;
         r_reg     <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         z_low_reg <= z_low_next;
         y_reg     <= y_next;
         rem_reg   <= rem_next;
         cnt_reg   <= cnt_next;
         q_reg     <= q_next;
         x_reg     <= x_next;
         r_reg     <= r_next;
         ovf_reg   <= ovf_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      z_low_next = z_low_reg;
      y_next     = y_reg;
      rem_next   = rem_reg;
      cnt_next   = cnt_reg;
      q_next     = q_reg;
      x_next     = x_reg;
      r_next     = r_reg;
      ovf_next   = ovf_reg;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;

      t        = {rem_reg, z_low_reg[cnt_reg]};
      t_ge     = (t >= {1'b0, y_reg});
      rem_step = t_ge ? N'(t - {1'b0, y_reg}) : t[N-1:0];
      quo      = {q_reg[N-2:0], t_ge};

      case (state_reg)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               z_low_next = bus.z[N-1:0];
               y_next     = bus.y;
               // A high half at or above y means the quotient cannot fit in N bits.
               if (bus.y == '0 || bus.z[2*N-1:N] >= bus.y) begin
                  state_next = DONE;
                  ovf_next   = 1'b1;
                  x_next     = '1;
                  r_next     = '0;
               end else begin
                  state_next = CALC;
                  rem_next   = bus.z[2*N-1:N];
                  cnt_next   = CW'(N - 1);
                  q_next     = '0;
                  ovf_next   = 1'b0;
               end
            end
         end
         CALC: begin
            rem_next = rem_step;
            q_next   = quo;
            cnt_next = cnt_reg - CW'(1);
            if (cnt_reg == '0) begin
               state_next = DONE;
               r_next     = rem_step;
`ifdef DIV_ROUND_EN
               if ({rem_step, 1'b0} >= {1'b0, y_reg}) begin
                  if (&quo) begin
                     x_next   = quo;
                     ovf_next = 1'b1;
                  end else begin
                     x_next = quo + N'(1);
                  end
               end else begin
                  x_next = quo;
               end
`else
               x_next = quo;
`endif
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.x   = x_reg;
   assign bus.r   = r_reg;
   assign bus.ovf = ovf_reg;
endmodule
